// File: rtl/tuner_pkg.sv
// Shared definitions for the tuner note encoder: string period table,
// note code constants and the measurement FSM states.
package tuner_pkg;

  localparam logic [3:0] NOTE_E2    = 4'h0;
  localparam logic [3:0] NOTE_A2    = 4'h1;
  localparam logic [3:0] NOTE_D3    = 4'h2;
  localparam logic [3:0] NOTE_G3    = 4'h3;
  localparam logic [3:0] NOTE_B3    = 4'h4;
  localparam logic [3:0] NOTE_E4    = 4'h5;
  localparam logic [3:0] NOTE_FLAT  = 4'h6;
  localparam logic [3:0] NOTE_SHARP = 4'h7;
  localparam logic [3:0] NOTE_BAD   = 4'hE;
  localparam logic [3:0] NOTE_NONE  = 4'hF;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_MEASURE,
    ST_EVAL
  } state_t;

  // Target period of each open string in 50 MHz clock cycles.
  function automatic logic [23:0] target_period(input logic [2:0] sel);
    logic [23:0] period;
    period = 24'd0;
    case (sel)
      3'd0:    period = 24'd606722;
      3'd1:    period = 24'd454545;
      3'd2:    period = 24'd340531;
      3'd3:    period = 24'd255102;
      3'd4:    period = 24'd202478;
      3'd5:    period = 24'd151685;
      default: period = 24'd0;
    endcase
    return period;
  endfunction

  function automatic logic [3:0] note_for_string(input logic [2:0] sel);
    logic [3:0] code;
    code = NOTE_BAD;
    case (sel)
      3'd0:    code = NOTE_E2;
      3'd1:    code = NOTE_A2;
      3'd2:    code = NOTE_D3;
      3'd3:    code = NOTE_G3;
      3'd4:    code = NOTE_B3;
      3'd5:    code = NOTE_E4;
      default: code = NOTE_BAD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/zero_cross_det.sv
// Hysteretic rising zero-crossing detector: arms on a sample at or below -HYST,
// fires xing on the next sample at or above +HYST.
module zero_cross_det #(
  parameter int SAMPLE_W = 16,
  parameter logic signed [SAMPLE_W-1:0] HYST = 16'sd512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                xing
);

  logic armed;
  logic arm_cond;
  logic fire_cond;

  assign arm_cond  = $signed(sample) <= -HYST;
  assign fire_cond = armed && ($signed(sample) >= HYST);
  assign xing      = sample_valid && fire_cond;

  always_ff @(posedge clk) begin
    if (reset) begin
      armed <= 1'b0;
    end else if (sample_valid) begin
      if (fire_cond) begin
        armed <= 1'b0;
      end else if (arm_cond) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_encoder.sv
// Tuner pitch measurement: averages 2**AVG_LOG2 crossing periods and encodes
// in-tune / flat / sharp / invalid-selection / no-signal as a 4-bit note code.
module note_encoder
  import tuner_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int CNT_W = 24,
  parameter int AVG_LOG2 = 2,
  parameter int TOL_SHIFT = 6,
  parameter logic signed [SAMPLE_W-1:0] HYST = 16'sd512,
  parameter int unsigned TIMEOUT_CYC = 2_500_000,
  parameter int PERIOD_SHIFT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [2:0]          string_sel,
  output logic [3:0]          note_code,
  output logic                code_valid
);

  localparam int W = CNT_W + 2;
  localparam logic [AVG_LOG2:0] N_LAST = (AVG_LOG2 + 1)'(2 ** AVG_LOG2 - 1);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_CYC);

  logic xing;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] acc_q, acc_n;
  logic [AVG_LOG2:0] n_q, n_n;
  logic [3:0] code_q, code_n;
  logic valid_q, valid_n;
  logic [2:0] sel_q;
  state_t state_q, state_n;

  logic [CNT_W:0] acc_add;
  logic [CNT_W-1:0] acc_sum;
  logic [W-1:0] period_w, target_sum, tol, upper, lower, acc_w;
  logic [3:0] decision;
  logic sel_bad, sel_changed, timeout;

  zero_cross_det #(
    .SAMPLE_W(SAMPLE_W),
    .HYST(HYST)
  ) u_zcd (
    .clk(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .sample(sample),
    .xing(xing)
  );

  // Period counter: restarts on every crossing, sticks at all-ones when starved.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (xing) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign acc_add = {1'b0, acc_q} + {1'b0, cnt_q};
  assign acc_sum = acc_add[CNT_W] ? '1 : acc_add[CNT_W-1:0];

  // The comparison uses the sum including the closing period, so the code
  // is registered on the very edge that ends the final crossing cycle.
  assign period_w   = W'(target_period(string_sel)) >> PERIOD_SHIFT;
  assign target_sum = period_w << AVG_LOG2;
  assign tol        = target_sum >> TOL_SHIFT;
  assign upper      = target_sum + tol;
  assign lower      = target_sum - tol;
  assign acc_w      = W'(acc_sum);

  always_comb begin
    decision = note_for_string(string_sel);
    if (acc_w > upper) begin
      decision = NOTE_FLAT;
    end else if (acc_w < lower) begin
      decision = NOTE_SHARP;
    end
  end

  assign sel_bad     = (string_sel >= 3'd6);
  assign sel_changed = (string_sel != sel_q);
  assign timeout     = (cnt_q >= TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SYNC;
      acc_q   <= '0;
      n_q     <= '0;
      code_q  <= NOTE_NONE;
      valid_q <= 1'b0;
      sel_q   <= '0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      n_q     <= n_n;
      code_q  <= code_n;
      valid_q <= valid_n;
      sel_q   <= string_sel;
    end
  end

  // Priority: invalid selection, then timeout, then selection change, then crossings.
  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    n_n     = n_q;
    code_n  = code_q;
    valid_n = 1'b0;

    if (sel_bad) begin
      state_n = ST_SYNC;
      acc_n   = '0;
      n_n     = '0;
      if (code_q != NOTE_BAD) begin
        code_n  = NOTE_BAD;
        valid_n = 1'b1;
      end
    end else if (timeout) begin
      state_n = ST_SYNC;
      acc_n   = '0;
      n_n     = '0;
      if (code_q != NOTE_NONE) begin
        code_n  = NOTE_NONE;
        valid_n = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_SYNC: begin
          if (xing) begin
            state_n = ST_MEASURE;
            acc_n   = '0;
            n_n     = '0;
          end
        end
        ST_MEASURE, ST_EVAL: begin
          state_n = ST_MEASURE;
          if (sel_changed) begin
            state_n = ST_SYNC;
            acc_n   = '0;
            n_n     = '0;
          end else if (xing) begin
            if (n_q == N_LAST) begin
              state_n = ST_EVAL;
              code_n  = decision;
              valid_n = 1'b1;
              acc_n   = '0;
              n_n     = '0;
            end else begin
              acc_n = acc_sum;
              n_n   = n_q + 1'b1;
            end
          end
        end
        default: begin
          state_n = ST_SYNC;
          acc_n   = '0;
          n_n     = '0;
        end
      endcase
    end
  end

  assign note_code  = code_q;
  assign code_valid = valid_q;

endmodule

// File: tb/tb_note_encoder.sv
// Scoreboard bench for note_encoder with the period table scaled down by 2**9
// and a matching timeout, so each decision takes a few thousand cycles.
module tb_note_encoder;

  localparam int PSHIFT  = 9;
  localparam int TIMEOUT = 4882;
  localparam int GAP_E2  = 1186;
  localparam int GAP_A2  = 888;
  localparam int GAP_D3  = 666;
  localparam logic [15:0] NEG = 16'hE0C0;
  localparam logic [15:0] POS = 16'h1F40;

  typedef struct {
    logic [3:0] code;
    int         at;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [15:0] sample;
  logic [2:0]  string_sel;
  logic [3:0]  note_code;
  logic        code_valid;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  note_encoder #(
    .TIMEOUT_CYC(TIMEOUT),
    .PERIOD_SHIFT(PSHIFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_valid(sample_valid),
    .sample(sample),
    .string_sel(string_sel),
    .note_code(note_code),
    .code_valid(code_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExpect(input logic [3:0] code, input int at);
    exp_t e;
    e.code = code;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // One crossing, `gap` cycles after the previous crossing cycle.
  task automatic applyStimulus(input int gap, input bit expect_pulse, input logic [3:0] code, input bit with_reset);
    sample = NEG;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (gap - 2) tick();
    sample = POS;
    sample_valid = 1'b1;
    if (with_reset) reset = 1'b1;
    if (expect_pulse) pushExpect(code, cyc + 1);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic window4(input int g1, input int g2, input int g3, input int g4, input logic [3:0] code);
    applyStimulus(g1, 1'b0, 4'h0, 1'b0);
    applyStimulus(g2, 1'b0, 4'h0, 1'b0);
    applyStimulus(g3, 1'b0, 4'h0, 1'b0);
    applyStimulus(g4, 1'b1, code, 1'b0);
  endtask

  // Monitor: every code_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (code_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pulse: got code %0h at cycle %0d, expected no pulse", note_code, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("pulse_code", 32'(note_code), 32'(mon_e.code));
        checkOutput("pulse_cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    reset = 1'b1;
    sample_valid = 1'b0;
    sample = '0;
    string_sel = 3'd1;

    $display("[TB] reset and silence");
    repeat (3) tick();
    checkOutput("reset_note", 32'(note_code), 32'hF);
    checkOutput("reset_valid", 32'(code_valid), 32'h0);
    reset = 1'b0;
    repeat (1000) tick();

    $display("[TB] A2 in tune");
    applyStimulus(10, 1'b0, 4'h0, 1'b0);
    window4(GAP_A2, GAP_A2, GAP_A2, GAP_A2, 4'h1);

    $display("[TB] A2 flat / sharp / boundaries");
    window4(940, 940, 940, 940, 4'h6);
    window4(860, 860, 860, 860, 4'h7);
    window4(901, 902, 902, 902, 4'h1);
    window4(902, 902, 902, 902, 4'h6);
    window4(874, 874, 874, 875, 4'h1);
    window4(874, 874, 874, 874, 4'h7);

    $display("[TB] timeout");
    pushExpect(4'hF, cyc - 1 + TIMEOUT + 2);
    repeat (5000) tick();
    applyStimulus(10, 1'b0, 4'h0, 1'b0);
    applyStimulus(GAP_A2, 1'b0, 4'h0, 1'b0);
    window4(GAP_A2, GAP_A2, GAP_A2, GAP_A2, 4'h1);
    applyStimulus(TIMEOUT + 1, 1'b1, 4'hF, 1'b0);
    applyStimulus(GAP_A2, 1'b0, 4'h0, 1'b0);
    window4(GAP_A2, GAP_A2, GAP_A2, GAP_A2, 4'h1);

    $display("[TB] invalid selection then E2");
    string_sel = 3'd6;
    pushExpect(4'hE, cyc + 1);
    repeat (3) applyStimulus(GAP_E2, 1'b0, 4'h0, 1'b0);
    string_sel = 3'd0;
    applyStimulus(GAP_E2, 1'b0, 4'h0, 1'b0);
    window4(GAP_E2, GAP_E2, GAP_E2, GAP_E2, 4'h0);

    $display("[TB] selection change and reset mid-window");
    string_sel = 3'd1;
    repeat (3) applyStimulus(GAP_D3, 1'b0, 4'h0, 1'b0);
    string_sel = 3'd2;
    applyStimulus(GAP_D3, 1'b0, 4'h0, 1'b0);
    window4(GAP_D3, GAP_D3, GAP_D3, GAP_D3, 4'h2);
    repeat (3) applyStimulus(GAP_D3, 1'b0, 4'h0, 1'b0);
    applyStimulus(GAP_D3, 1'b0, 4'h0, 1'b1);
    checkOutput("midreset_note", 32'(note_code), 32'hF);
    checkOutput("midreset_valid", 32'(code_valid), 32'h0);
    reset = 1'b0;
    repeat (20) tick();

    checkOutput("pending_expectations", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
